branch_resolution_unit: RTL
===========================

# branch_resolution_unit

Execute-stage partner of the static branch predictor. It tracks each fetched instruction's predicted direction through IF→ID→EX, in lock-step with the predictor's not-predicted-offset pipeline. It resolves BT/BF against the ALU condition in EX and raises `guess_wrong` with the recovery offset and front-end flushes on a mispredict. It also keeps saturating branch and mispredict counters for performance debug.

## Interface
- `CNT_W`, default 16: width of each performance counter.

- `clk` in 1: core clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: pipeline stall; holds all stage registers.
- `halted` in 1: core halted; same effect as `stall`.
- `fetch_valid` in 1: IF holds a real instruction.
- `opcode_IF` in 5: opcode of the instruction in IF.
- `branch_target_IF` in 17: signed branch offset of the instruction in IF.
- `opcode_EX` in 5: opcode of the instruction in EX.
- `cond` in 1: ALU condition result for the EX instruction (1 = true).
- `not_predicted_offset` in 17: recovery offset from the predictor, aligned to EX.
- `cnt_clear` in 1: synchronous clear of both counters.
- `guess_wrong` out 1: EX branch mispredicted this cycle.
- `redirect_offset` out 17: PC offset to apply when `guess_wrong`.
- `flush_IF` out 1: kill the instruction in IF.
- `flush_ID` out 1: kill the instruction in ID.
- `branch_count` out CNT_W: resolved BT/BF count.
- `mispredict_count` out CNT_W: mispredict count.

## Operation
- Opcodes: BT = 23, BF = 24, JAL = 25.
- IF prediction, `pt_IF`:
  - 1 for BT/BF with `$signed(branch_target_IF) < 0`.
  - 1 for JAL.
  - 0 otherwise.
- Stage registers (`valid_ID`, `pt_ID`, `valid_EX`, `pt_EX`):
  - Advance IF→ID→EX on every edge with `!stall && !halted`.
  - Hold when `stall || halted`.
  - `valid_ID` loads `fetch_valid`.
- Flush: when `guess_wrong` is 1 at an edge, `valid_ID` and `valid_EX` load 0, not the upstream values. The wrong-path IF and ID instructions become bubbles.
- Resolution qualifier `res` = `valid_EX && !stall && !halted && (opcode_EX == BT || opcode_EX == BF)`.
- Actual direction `taken` = `cond` for BT, `!cond` for BF.
- `guess_wrong` = `res && (taken != pt_EX)`. It is combinational from registered state plus `cond`.
- JAL never mispredicts and is never counted.
- `redirect_offset` = `not_predicted_offset` when `guess_wrong`, else 0.
- `flush_IF` = `flush_ID` = `guess_wrong`.
- Counters:
  - `branch_count` increments on each edge where `res` is 1.
  - `mispredict_count` increments on each edge where `guess_wrong` is 1.
  - Both saturate at all-ones.
  - `cnt_clear` has priority over increment; that edge's event is dropped.
- A stalled branch in EX resolves exactly once, on the first non-stalled cycle. It never raises `guess_wrong` while stalled.

## Timing
- Prediction latency: IF to EX is 2 unstalled edges, matching the predictor's offset pipeline.
- Mispredict detected in cycle N:
  - `guess_wrong`, `flush_IF`, `flush_ID` and `redirect_offset` are valid in cycle N.
  - Bubbles occupy ID and EX in cycle N+1.
  - The counter update is visible in cycle N+1.
- Back-to-back mispredicts are impossible: the instruction following a mispredict is always a bubble.
- Reset values:
  - All `valid_*` and `pt_*` are 0.
  - Counters are 0.
  - Hence `guess_wrong`, `flush_IF`, `flush_ID` = 0 and `redirect_offset` = 0.
- Reset mid-operation discards in-flight predictions immediately (asynchronous).
- Counter wrap: never. Saturation holds until `cnt_clear` or `rst`.

## Test plan
- BF with `branch_target_IF` = −4 (predicted taken) reaches EX with `cond` = 1, `not_predicted_offset` = 4:
  - `guess_wrong` = 1, `redirect_offset` = 4, both flushes 1.
  - Next cycle `valid_EX` = 0; `mispredict_count` = 1, `branch_count` = 1.
- BT with `branch_target_IF` = +8 (predicted not-taken), `cond` = 0 in EX:
  - No `guess_wrong`; `branch_count` +1, `mispredict_count` unchanged.
- Mispredicting BT held in EX by `stall` = 1 for 3 cycles:
  - `guess_wrong` = 0 throughout the stall.
  - `guess_wrong` = 1 for exactly one cycle after release; counters +1 once.
- Mispredict followed by an IF branch that would also mispredict:
  - The flushed branch produces no `guess_wrong` and no counter increment.
- Preload `mispredict_count` to 0xFFFF (`CNT_W` = 16), then mispredict: it stays 0xFFFF. Assert `cnt_clear` during a branch resolve: both counters read 0 next cycle.
- Assert `rst` asynchronously while a mispredicting branch sits in ID:
  - Outputs go 0 immediately.
  - No `guess_wrong` after `rst` deasserts.

Source files
------------

// File: rtl/branch_resolution_unit.sv
// rtl/branch_resolution_unit.sv - EX-stage branch resolution with mispredict flush and perf counters
module branch_resolution_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halted,
    input  logic             fetch_valid,
    input  logic [4:0]       opcode_IF,
    input  logic [16:0]      branch_target_IF,
    input  logic [4:0]       opcode_EX,
    input  logic             cond,
    input  logic [16:0]      not_predicted_offset,
    input  logic             cnt_clear,
    output logic             guess_wrong,
    output logic [16:0]      redirect_offset,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam logic [4:0] OP_BT  = 5'd23;
    localparam logic [4:0] OP_BF  = 5'd24;
    localparam logic [4:0] OP_JAL = 5'd25;

    logic pt_IF;
    logic valid_ID;
    logic pt_ID;
    logic valid_EX;
    logic pt_EX;
    logic advance;
    logic is_cond_branch_EX;
    logic res;
    logic taken;

    // Static prediction: backward conditional branches and JAL are taken
    always_comb begin
        pt_IF = 1'b0;
        if ((opcode_IF == OP_BT || opcode_IF == OP_BF) && $signed(branch_target_IF) < 0)
            pt_IF = 1'b1;
        else if (opcode_IF == OP_JAL)
            pt_IF = 1'b1;
    end

    assign advance           = !stall && !halted;
    assign is_cond_branch_EX = (opcode_EX == OP_BT) || (opcode_EX == OP_BF);

    // Resolve only when the EX instruction actually leaves EX this cycle, so a
    // stalled branch is counted and flagged exactly once
    assign res         = valid_EX && advance && is_cond_branch_EX;
    assign taken       = (opcode_EX == OP_BT) ? cond : !cond;
    assign guess_wrong = res && (taken != pt_EX);

    assign redirect_offset = guess_wrong ? not_predicted_offset : 17'd0;
    assign flush_IF        = guess_wrong;
    assign flush_ID        = guess_wrong;

    // Prediction pipeline IF->ID->EX; a mispredict turns the wrong-path slots into bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_ID <= 1'b0;
            pt_ID    <= 1'b0;
            valid_EX <= 1'b0;
            pt_EX    <= 1'b0;
        end else if (advance) begin
            valid_ID <= guess_wrong ? 1'b0 : fetch_valid;
            pt_ID    <= pt_IF;
            valid_EX <= guess_wrong ? 1'b0 : valid_ID;
            pt_EX    <= pt_ID;
        end
    end

    // Saturating performance counters; clear wins over a same-edge event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (cnt_clear) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (res && branch_count != {CNT_W{1'b1}})
                branch_count <= branch_count + CNT_W'(1);
            if (guess_wrong && mispredict_count != {CNT_W{1'b1}})
                mispredict_count <= mispredict_count + CNT_W'(1);
        end
    end

endmodule
